packet_arbiter: RTL and testbench

- Round-robin, packet-atomic arbiter that merges up to 2^SBITS AXI-Stream packet sources onto one output stream.
- Each source is normally the read port of a `packet_fifo`, so only whole, committed packets are offered.
- Sits between the per-requester packet FIFOs and the shared downstream consumer; the command/response path toward the DDR3 controller.
- Once granted, a source keeps the output until its `tlast` beat is accepted.
- The output is a single register stage carrying data, last and source ID.

---
 rtl/packet_arbiter.sv | 89 ++++++++
 tb/tb_packet_arbiter.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/packet_arbiter.sv
// Packet-atomic round-robin arbiter: merges NUM_SRC AXI-Stream sources onto one
// registered output stream, holding a grant until the granted source's tlast beat is taken.
module packet_arbiter #(
  parameter int WIDTH = 8,
  parameter int SBITS = 2
) (
  input  logic                            clock,
  input  logic                            reset_n,
  input  logic [(1<<SBITS)-1:0]           s_tvalid,
  output logic [(1<<SBITS)-1:0]           s_tready,
  input  logic [(1<<SBITS)-1:0]           s_tlast,
  input  logic [(1<<SBITS)*WIDTH-1:0]     s_tdata,
  output logic                            m_tvalid,
  input  logic                            m_tready,
  output logic                            m_tlast,
  output logic [SBITS-1:0]                m_tid,
  output logic [WIDTH-1:0]                m_tdata,
  output logic                            busy_o
);

  localparam int NUM_SRC = 1 << SBITS;

  typedef enum logic {IDLE, XFER} state_t;

  state_t           state;
  logic [SBITS-1:0] grant;
  logic [SBITS-1:0] ptr;
  logic [SBITS-1:0] next_grant;
  logic [SBITS-1:0] cand;
  logic             found;
  logic             oready;
  logic             accept;

  // First requester at or after ptr, wrapping; the SBITS-wide add gives the modulo for free.
  always_comb begin
    next_grant = ptr;
    cand       = ptr;
    found      = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      cand = ptr + SBITS'(i);
      if (!found && s_tvalid[cand]) begin
        next_grant = cand;
        found      = 1'b1;
      end
    end
  end

  assign oready = !m_tvalid || m_tready;
  assign accept = (state == XFER) && s_tvalid[grant] && oready;
  assign busy_o = (state == XFER);

  always_comb begin
    s_tready = '0;
    if (state == XFER) s_tready[grant] = oready;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      grant    <= '0;
      ptr      <= '0;
      m_tvalid <= 1'b0;
      m_tlast  <= 1'b0;
      m_tid    <= '0;
      m_tdata  <= '0;
    end else begin
      if (state == IDLE) begin
        if (found) begin
          grant <= next_grant;
          state <= XFER;
        end
      end else if (accept && s_tlast[grant]) begin
        ptr   <= grant + SBITS'(1);
        state <= IDLE;
      end

      // The output register only reloads on an accepted beat, so it is stable while stalled.
      if (accept) begin
        m_tvalid <= 1'b1;
        m_tdata  <= s_tdata[grant*WIDTH +: WIDTH];
        m_tlast  <= s_tlast[grant];
        m_tid    <= grant;
      end else if (m_tready) begin
        m_tvalid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_packet_arbiter.sv
// Self-checking bench for packet_arbiter: a cycle table for the single-source case and a
// source model with an expected-beat queue for arbitration order, backpressure and reset.
module tb_packet_arbiter;

  localparam int WIDTH   = 8;
  localparam int SBITS   = 2;
  localparam int NUM_SRC = 4;

  logic                     clock = 1'b0;
  logic                     reset_n;
  logic [NUM_SRC-1:0]       s_tvalid;
  logic [NUM_SRC-1:0]       s_tready;
  logic [NUM_SRC-1:0]       s_tlast;
  logic [NUM_SRC*WIDTH-1:0] s_tdata;
  logic                     m_tvalid;
  logic                     m_tready;
  logic                     m_tlast;
  logic [SBITS-1:0]         m_tid;
  logic [WIDTH-1:0]         m_tdata;
  logic                     busy_o;

  packet_arbiter #(.WIDTH(WIDTH), .SBITS(SBITS)) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .s_tvalid (s_tvalid),
    .s_tready (s_tready),
    .s_tlast  (s_tlast),
    .s_tdata  (s_tdata),
    .m_tvalid (m_tvalid),
    .m_tready (m_tready),
    .m_tlast  (m_tlast),
    .m_tid    (m_tid),
    .m_tdata  (m_tdata),
    .busy_o   (busy_o)
  );

  always #5 clock = ~clock;

  typedef struct packed { logic [7:0] data; logic last; } beat_t;
  typedef struct packed { logic [1:0] tid; logic [7:0] data; logic last; } exp_t;
  typedef struct {
    logic [3:0] sv;
    logic [3:0] sl;
    logic [7:0] d;
    logic [3:0] e_sready;
    logic       e_mvalid;
    logic [7:0] e_data;
    logic       e_last;
    logic       e_busy;
  } vec_t;

  beat_t      src_q[NUM_SRC][$];
  exp_t       exp_q[$];
  bit         rdy_pat[$];
  vec_t       vecs[6];
  logic [3:0] acc;
  int         checks    = 0;
  int         errors    = 0;
  int         cycle     = 0;
  int         pops      = 0;
  int         first_pop = -1;
  int         last_pop  = -1;
  int         pops_before;
  int         n;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] v, input logic [3:0] l,
                               input logic [31:0] d, input logic r);
    s_tvalid = v;
    s_tlast  = l;
    s_tdata  = d;
    m_tready = r;
  endtask

  task automatic monitor();
    exp_t e;
    checkOutput("sready_onehot0", 32'($onehot0(s_tready)), 32'd1);
    if (m_tvalid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_beat: got tid=%0d data=0x%0h, expected no beat", m_tid, m_tdata);
      end else begin
        e = exp_q[0];
        checkOutput(m_tready ? "beat" : "held_beat",
                    {21'b0, m_tid, m_tdata, m_tlast}, {21'b0, e.tid, e.data, e.last});
        if (m_tready) begin
          void'(exp_q.pop_front());
          pops++;
          if (first_pop < 0) first_pop = cycle;
          last_pop = cycle;
        end else begin
          checkOutput("sready_stall", 32'(s_tready), 32'd0);
        end
      end
    end
  endtask

  task automatic step();
    logic [3:0]  v;
    logic [3:0]  l;
    logic [31:0] d;
    logic        r;
    @(negedge clock);
    monitor();
    acc = s_tvalid & s_tready;
    @(posedge clock);
    #1;
    cycle++;
    v = '0;
    l = '0;
    d = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (acc[k] && src_q[k].size() > 0) void'(src_q[k].pop_front());
      if (src_q[k].size() > 0) begin
        v[k]         = 1'b1;
        l[k]         = src_q[k][0].last;
        d[k*8 +: 8]  = src_q[k][0].data;
      end
    end
    r = (rdy_pat.size() > 0) ? rdy_pat.pop_front() : 1'b1;
    applyStimulus(v, l, d, r);
  endtask

  // Call order defines the expected arbitration order.
  task automatic add_packet(input int src, input int len, input logic [7:0] base);
    for (int b = 0; b < len; b++) begin
      src_q[src].push_back('{data: base + 8'(b), last: (b == len - 1)});
      exp_q.push_back('{tid: 2'(src), data: base + 8'(b), last: (b == len - 1)});
    end
  endtask

  task automatic run_until_empty(input string name, input int budget);
    int k = 0;
    while (exp_q.size() > 0 && k < budget) begin
      step();
      k++;
    end
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s_timeout: got %0d beats outstanding, expected 0", name, exp_q.size());
      exp_q.delete();
    end
    repeat (3) step();
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    for (int k = 0; k < NUM_SRC; k++) src_q[k].delete();
    exp_q.delete();
    rdy_pat.delete();
    applyStimulus(4'b0, 4'b0, 32'b0, 1'b1);
    repeat (2) begin
      @(posedge clock);
      #1;
    end
    reset_n = 1'b1;
  endtask

  initial begin
    vecs[0] = '{4'b0100, 4'b0000, 8'hA1, 4'b0000, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[1] = '{4'b0101, 4'b0000, 8'hA1, 4'b0100, 1'b0, 8'h00, 1'b0, 1'b1};
    vecs[2] = '{4'b0111, 4'b0000, 8'hA2, 4'b0100, 1'b1, 8'hA1, 1'b0, 1'b1};
    vecs[3] = '{4'b0110, 4'b0100, 8'hA3, 4'b0100, 1'b1, 8'hA2, 1'b0, 1'b1};
    vecs[4] = '{4'b0000, 4'b0000, 8'h00, 4'b0000, 1'b1, 8'hA3, 1'b1, 1'b0};
    vecs[5] = '{4'b0000, 4'b0000, 8'h00, 4'b0000, 1'b0, 8'h00, 1'b0, 1'b0};

    reset_n = 1'b0;
    applyStimulus(4'b0, 4'b0, 32'b0, 1'b1);
    repeat (2) begin
      @(posedge clock);
      #1;
    end
    checkOutput("rst_mvalid", 32'(m_tvalid), 32'd0);
    checkOutput("rst_mlast",  32'(m_tlast),  32'd0);
    checkOutput("rst_mtid",   32'(m_tid),    32'd0);
    checkOutput("rst_mdata",  32'(m_tdata),  32'd0);
    checkOutput("rst_sready", 32'(s_tready), 32'd0);
    checkOutput("rst_busy",   32'(busy_o),   32'd0);
    reset_n = 1'b1;

    $display("[TB] idle after reset release");
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      checkOutput("idle_mvalid", 32'(m_tvalid), 32'd0);
      checkOutput("idle_busy",   32'(busy_o),   32'd0);
      checkOutput("idle_sready", 32'(s_tready), 32'd0);
      @(posedge clock);
      #1;
    end

    $display("[TB] single source 2, three beats, other sources toggling");
    for (int i = 0; i < 6; i++) begin
      applyStimulus(vecs[i].sv, vecs[i].sl, {8'h55, vecs[i].d, 8'h55, 8'h55}, 1'b1);
      @(negedge clock);
      checkOutput($sformatf("tbl%0d_sready", i), 32'(s_tready), 32'(vecs[i].e_sready));
      checkOutput($sformatf("tbl%0d_mvalid", i), 32'(m_tvalid), 32'(vecs[i].e_mvalid));
      checkOutput($sformatf("tbl%0d_busy", i),   32'(busy_o),   32'(vecs[i].e_busy));
      if (vecs[i].e_mvalid) begin
        checkOutput($sformatf("tbl%0d_mdata", i), 32'(m_tdata), 32'(vecs[i].e_data));
        checkOutput($sformatf("tbl%0d_mlast", i), 32'(m_tlast), 32'(vecs[i].e_last));
        checkOutput($sformatf("tbl%0d_mtid", i),  32'(m_tid),   32'd2);
      end
      @(posedge clock);
      #1;
    end

    $display("[TB] skip and wrap from ptr=3");
    add_packet(0, 2, 8'h10);
    add_packet(1, 2, 8'h20);
    run_until_empty("skip_wrap", 40);

    $display("[TB] single-beat packets ordered from ptr=2");
    add_packet(3, 1, 8'h30);
    add_packet(0, 1, 8'h40);
    run_until_empty("ptr_order", 40);

    $display("[TB] round-robin, all sources requesting");
    do_reset();
    first_pop = -1;
    last_pop  = -1;
    for (int p = 0; p < 2; p++)
      for (int k = 0; k < NUM_SRC; k++)
        add_packet(k, 2, 8'(k * 16 + p * 4));
    run_until_empty("round_robin", 200);
    checkOutput("rr_span", 32'(last_pop - first_pop), 32'd22);

    $display("[TB] backpressure on source 1");
    add_packet(1, 4, 8'hD0);
    foreach (vecs[0].sv[b]) begin end
    rdy_pat.push_back(1'b1);
    rdy_pat.push_back(1'b0);
    rdy_pat.push_back(1'b0);
    rdy_pat.push_back(1'b1);
    rdy_pat.push_back(1'b1);
    rdy_pat.push_back(1'b0);
    rdy_pat.push_back(1'b1);
    rdy_pat.push_back(1'b1);
    run_until_empty("backpressure", 60);

    $display("[TB] asynchronous reset during beat 2 of 5");
    pops_before = pops;
    add_packet(2, 5, 8'hE0);
    n = 0;
    while (pops - pops_before < 1 && n < 20) begin
      step();
      n++;
    end
    checkOutput("mid_reach_beat2", 32'(pops - pops_before), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("async_mvalid", 32'(m_tvalid), 32'd0);
    checkOutput("async_sready", 32'(s_tready), 32'd0);
    checkOutput("async_busy",   32'(busy_o),   32'd0);
    for (int k = 0; k < NUM_SRC; k++) src_q[k].delete();
    exp_q.delete();
    applyStimulus(4'b0, 4'b0, 32'b0, 1'b1);
    repeat (2) begin
      @(posedge clock);
      #1;
    end
    reset_n = 1'b1;

    $display("[TB] arbitration restarts from ptr=0");
    add_packet(1, 2, 8'h70);
    add_packet(3, 2, 8'h60);
    run_until_empty("post_reset", 40);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
